// File: rtl/id_fwd_stage_pkg.sv
// Shared decode constants and the instruction decode helper for the ID stage.
package id_fwd_stage_pkg;

    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;

    localparam logic [5:0] EXE_AND = 6'b100100;
    localparam logic [5:0] EXE_OR  = 6'b100101;
    localparam logic [5:0] EXE_XOR = 6'b100110;
    localparam logic [5:0] EXE_NOR = 6'b100111;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;

    localparam logic [4:0]  NOPRegAddr = 5'b00000;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [4:0]  wd;
        logic        wreg;
        logic        instvalid;
        logic        reg1_read;
        logic        reg2_read;
        logic        reg2_imm;
        logic [31:0] imm;
    } decode_t;

    // Fields are passed individually so the caller decides which bits are consumed.
    function automatic decode_t decode_inst(input logic [5:0]  op,
                                            input logic [5:0]  funct,
                                            input logic [4:0]  rt,
                                            input logic [4:0]  rd,
                                            input logic [15:0] imm16);
        decode_t d;
        d.aluop     = EXE_NOP_OP;
        d.alusel    = EXE_RES_NOP;
        d.wd        = NOPRegAddr;
        d.wreg      = 1'b0;
        d.instvalid = 1'b0;
        d.reg1_read = 1'b0;
        d.reg2_read = 1'b0;
        d.reg2_imm  = 1'b0;
        d.imm       = ZeroWord;
        case (op)
            EXE_ORI, EXE_ANDI, EXE_XORI: begin
                d.aluop     = (op == EXE_ORI)  ? EXE_OR_OP  :
                              (op == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
                d.alusel    = EXE_RES_LOGIC;
                d.wd        = rt;
                d.wreg      = 1'b1;
                d.instvalid = 1'b1;
                d.reg1_read = 1'b1;
                d.reg2_imm  = 1'b1;
                d.imm       = {16'h0000, imm16};
            end
            // LUI carries its shifted immediate on operand 1 and ORs it with zero.
            EXE_LUI: begin
                d.aluop     = EXE_OR_OP;
                d.alusel    = EXE_RES_LOGIC;
                d.wd        = rt;
                d.wreg      = 1'b1;
                d.instvalid = 1'b1;
                d.imm       = {imm16, 16'h0000};
            end
            EXE_SPECIAL: begin
                if (funct == EXE_AND || funct == EXE_OR ||
                    funct == EXE_XOR || funct == EXE_NOR) begin
                    d.aluop     = {2'b00, funct};
                    d.alusel    = EXE_RES_LOGIC;
                    d.wd        = rd;
                    d.wreg      = 1'b1;
                    d.instvalid = 1'b1;
                    d.reg1_read = 1'b1;
                    d.reg2_read = 1'b1;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_fwd_stage_fwd_mux.sv
// Per-operand forwarding select: youngest matching source wins, $0 never forwards.
module id_fwd_stage_fwd_mux #(
    parameter int NUM_FWD = 2,
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5
) (
    input  logic [REG_AW-1:0]         addr,
    input  logic [DATA_W-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]        fwd_wreg,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    input  logic [NUM_FWD-1:0]        fwd_pend,
    output logic [DATA_W-1:0]         data,
    output logic                      pend
);

    // Scan oldest to youngest so the lowest-index match overwrites the rest.
    always_comb begin
        data = rf_data;
        pend = 1'b0;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwd_wreg[k] && fwd_wd[k*REG_AW +: REG_AW] == addr) begin
                data = fwd_wdata[k*DATA_W +: DATA_W];
                pend = fwd_pend[k];
            end
        end
        if (addr == '0) begin
            data = '0;
            pend = 1'b0;
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// Registered decode stage: logic-class decode, operand forwarding, load-use stall.
module id_fwd_stage
    import id_fwd_stage_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               pc_i,
    input  logic [31:0]               inst_i,
    output logic [REG_AW-1:0]         reg1_addr_o,
    output logic [REG_AW-1:0]         reg2_addr_o,
    input  logic [DATA_W-1:0]         reg1_data_i,
    input  logic [DATA_W-1:0]         reg2_data_i,
    input  logic [NUM_FWD-1:0]        fwd_wreg_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
    input  logic [NUM_FWD-1:0]        fwd_pend_i,
    input  logic                      flush_i,
    input  logic                      ex_ready_i,
    output logic                      out_valid_o,
    output logic [31:0]               pc_o,
    output logic [7:0]                aluop_o,
    output logic [2:0]                alusel_o,
    output logic [DATA_W-1:0]         reg1_o,
    output logic [DATA_W-1:0]         reg2_o,
    output logic [REG_AW-1:0]         wd_o,
    output logic                      wreg_o,
    output logic                      instvalid_o,
    output logic [15:0]               stall_cnt_o
);

    decode_t             dec;
    logic [DATA_W-1:0]   op1_data, op2_data;
    logic                op1_pend, op2_pend;
    logic [DATA_W-1:0]   reg1_nx, reg2_nx;
    logic                hazard;
    logic                unused_shamt;

    assign dec = decode_inst(inst_i[31:26], inst_i[5:0], inst_i[20:16],
                             inst_i[15:11], inst_i[15:0]);
    assign unused_shamt = ^inst_i[10:6];

    assign reg1_addr_o = inst_i[25:21];
    assign reg2_addr_o = inst_i[20:16];

    id_fwd_stage_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux1 (
        .addr      (reg1_addr_o),
        .rf_data   (reg1_data_i),
        .fwd_wreg  (fwd_wreg_i),
        .fwd_wd    (fwd_wd_i),
        .fwd_wdata (fwd_wdata_i),
        .fwd_pend  (fwd_pend_i),
        .data      (op1_data),
        .pend      (op1_pend)
    );

    id_fwd_stage_fwd_mux #(.NUM_FWD(NUM_FWD), .DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux2 (
        .addr      (reg2_addr_o),
        .rf_data   (reg2_data_i),
        .fwd_wreg  (fwd_wreg_i),
        .fwd_wd    (fwd_wd_i),
        .fwd_wdata (fwd_wdata_i),
        .fwd_pend  (fwd_pend_i),
        .data      (op2_data),
        .pend      (op2_pend)
    );

    assign reg1_nx = dec.reg1_read ? op1_data : dec.imm;
    assign reg2_nx = dec.reg2_read ? op2_data : (dec.reg2_imm ? dec.imm : ZeroWord);

    // Only operands that are actually read can stall on a pending result.
    assign hazard   = in_valid & ((dec.reg1_read & op1_pend) | (dec.reg2_read & op2_pend));
    assign in_ready = flush_i | (!hazard & (ex_ready_i | !out_valid_o));

    // Output register: flush drops, free slot loads or bubbles, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            pc_o        <= ZeroWord;
            aluop_o     <= EXE_NOP_OP;
            alusel_o    <= EXE_RES_NOP;
            reg1_o      <= '0;
            reg2_o      <= '0;
            wd_o        <= '0;
            wreg_o      <= 1'b0;
            instvalid_o <= 1'b0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (ex_ready_i || !out_valid_o) begin
            if (in_valid && !hazard) begin
                out_valid_o <= 1'b1;
                pc_o        <= pc_i;
                aluop_o     <= dec.aluop;
                alusel_o    <= dec.alusel;
                reg1_o      <= reg1_nx;
                reg2_o      <= reg2_nx;
                wd_o        <= dec.wd;
                wreg_o      <= dec.wreg;
                instvalid_o <= dec.instvalid;
            end else begin
                out_valid_o <= 1'b0;
            end
        end
    end

    // Saturating stall counter; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= 16'h0000;
        end else if (hazard && !flush_i && stall_cnt_o != 16'hFFFF) begin
            stall_cnt_o <= stall_cnt_o + 16'h0001;
        end
    end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage with hand-computed expected values.
module tb_id_fwd_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_i, inst_i;
    logic [4:0]  reg1_addr_o, reg2_addr_o;
    logic [31:0] reg1_data_i, reg2_data_i;
    logic [1:0]  fwd_wreg_i;
    logic [9:0]  fwd_wd_i;
    logic [63:0] fwd_wdata_i;
    logic [1:0]  fwd_pend_i;
    logic        flush_i, ex_ready_i;
    logic        out_valid_o;
    logic [31:0] pc_o;
    logic [7:0]  aluop_o;
    logic [2:0]  alusel_o;
    logic [31:0] reg1_o, reg2_o;
    logic [4:0]  wd_o;
    logic        wreg_o, instvalid_o;
    logic [15:0] stall_cnt_o;

    logic [31:0] rf [32];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign reg1_data_i = rf[reg1_addr_o];
    assign reg2_data_i = rf[reg2_addr_o];

    id_fwd_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .inst_i(inst_i),
        .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
        .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
        .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
        .fwd_wdata_i(fwd_wdata_i), .fwd_pend_i(fwd_pend_i),
        .flush_i(flush_i), .ex_ready_i(ex_ready_i),
        .out_valid_o(out_valid_o), .pc_o(pc_o), .aluop_o(aluop_o),
        .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o),
        .wreg_o(wreg_o), .instvalid_o(instvalid_o), .stall_cnt_o(stall_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] i_imm(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] i_r(input logic [5:0] funct, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    task automatic no_fwd();
        fwd_wreg_i  = 2'b00;
        fwd_wd_i    = 10'd0;
        fwd_wdata_i = 64'd0;
        fwd_pend_i  = 2'b00;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rf[1] = 32'h1111_1111;
        rf[2] = 32'h2222_2222;
        rst = 1'b1; in_valid = 1'b0; pc_i = 32'h0; inst_i = 32'h0;
        flush_i = 1'b0; ex_ready_i = 1'b1;
        no_fwd();
        step(); step();
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("rst_aluop", {24'd0, aluop_o}, 32'd0);
        chk("rst_reg1", reg1_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_stall", {16'd0, stall_cnt_o}, 32'd0);

        // ORI $1,$0,0x1234
        in_valid = 1'b1; pc_i = 32'h100; inst_i = i_imm(6'b001101, 5'd1, 5'd0, 16'h1234);
        #1 chk("ori_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("ori_valid", {31'd0, out_valid_o}, 32'd1);
        chk("ori_reg1", reg1_o, 32'h0);
        chk("ori_reg2", reg2_o, 32'h0000_1234);
        chk("ori_wd", {27'd0, wd_o}, 32'd1);
        chk("ori_wreg", {31'd0, wreg_o}, 32'd1);
        chk("ori_aluop", {24'd0, aluop_o}, 32'h25);
        chk("ori_alusel", {29'd0, alusel_o}, 32'd1);
        chk("ori_pc", pc_o, 32'h100);

        // OR $3,$1,$2 with both sources writing $1: index 0 wins, $2 from RF
        pc_i = 32'h104; inst_i = i_r(6'b100101, 5'd3, 5'd1, 5'd2);
        fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1};
        fwd_wdata_i = {32'h0000_5555, 32'hAAAA_0000};
        step();
        chk("or_reg1", reg1_o, 32'hAAAA_0000);
        chk("or_reg2", reg2_o, 32'h2222_2222);
        chk("or_wd", {27'd0, wd_o}, 32'd3);

        // AND $3,$1,$2 with only source 1 writing $2
        pc_i = 32'h108; inst_i = i_r(6'b100100, 5'd3, 5'd1, 5'd2);
        fwd_wreg_i = 2'b10; fwd_wd_i = {5'd2, 5'd1};
        step();
        chk("and_reg1", reg1_o, 32'h1111_1111);
        chk("and_reg2", reg2_o, 32'h0000_5555);
        chk("and_aluop", {24'd0, aluop_o}, 32'h24);

        // XOR $5,$1,$0: pending source 1 shadowed by ready source 0, $0 is zero
        pc_i = 32'h10C; inst_i = i_r(6'b100110, 5'd5, 5'd1, 5'd0);
        fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_pend_i = 2'b10;
        #1 chk("shadow_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("shadow_reg1", reg1_o, 32'hAAAA_0000);
        chk("shadow_reg2", reg2_o, 32'h0);
        chk("shadow_stall", {16'd0, stall_cnt_o}, 32'd0);

        // ANDI $6,$1,0xFF with source 0 pending on $1 for two cycles
        pc_i = 32'h110; inst_i = i_imm(6'b001100, 5'd6, 5'd1, 16'h00FF);
        fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1};
        fwd_wdata_i = {32'h0, 32'h0000_F0F0}; fwd_pend_i = 2'b01;
        for (int c = 0; c < 2; c++) begin
            #1 chk("haz_ready", {31'd0, in_ready}, 32'd0);
            step();
            chk("haz_bubble", {31'd0, out_valid_o}, 32'd0);
        end
        fwd_pend_i = 2'b00;
        #1 chk("haz_release", {31'd0, in_ready}, 32'd1);
        step();
        chk("haz_valid", {31'd0, out_valid_o}, 32'd1);
        chk("haz_reg1", reg1_o, 32'h0000_F0F0);
        chk("haz_reg2", reg2_o, 32'h0000_00FF);
        chk("haz_pc", pc_o, 32'h110);
        chk("haz_stall", {16'd0, stall_cnt_o}, 32'd2);

        // Backpressure: ORI loaded, then EX stalls for 3 cycles holding it
        no_fwd();
        pc_i = 32'h200; inst_i = i_imm(6'b001101, 5'd7, 5'd0, 16'h7777);
        step();
        chk("bp_first", pc_o, 32'h200);
        ex_ready_i = 1'b0;
        pc_i = 32'h204; inst_i = i_imm(6'b001110, 5'd8, 5'd0, 16'h8888);
        for (int c = 0; c < 3; c++) begin
            #1 chk("bp_ready", {31'd0, in_ready}, 32'd0);
            step();
            chk("bp_hold_pc", pc_o, 32'h200);
            chk("bp_hold_reg2", reg2_o, 32'h0000_7777);
            chk("bp_hold_valid", {31'd0, out_valid_o}, 32'd1);
        end
        ex_ready_i = 1'b1;
        #1 chk("bp_resume", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_next_pc", pc_o, 32'h204);
        chk("bp_next_reg2", reg2_o, 32'h0000_8888);
        chk("bp_next_aluop", {24'd0, aluop_o}, 32'h26);
        in_valid = 1'b0;
        step();
        chk("bp_no_dup", {31'd0, out_valid_o}, 32'd0);

        // Flush while stalled on a held instruction
        in_valid = 1'b1; pc_i = 32'h300; inst_i = i_imm(6'b001101, 5'd9, 5'd0, 16'h0001);
        step();
        chk("fl_loaded", {31'd0, out_valid_o}, 32'd1);
        ex_ready_i = 1'b0;
        pc_i = 32'h304; inst_i = i_r(6'b100101, 5'd9, 5'd1, 5'd2);
        fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd1}; fwd_pend_i = 2'b01;
        flush_i = 1'b1;
        #1 chk("fl_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("fl_valid", {31'd0, out_valid_o}, 32'd0);
        chk("fl_stall", {16'd0, stall_cnt_o}, 32'd2);
        flush_i = 1'b0; ex_ready_i = 1'b1; no_fwd();

        // Undefined opcode flows through as invalid
        pc_i = 32'h400; inst_i = 32'hFC00_0000;
        step();
        chk("undef_valid", {31'd0, out_valid_o}, 32'd1);
        chk("undef_inst", {31'd0, instvalid_o}, 32'd0);
        chk("undef_wreg", {31'd0, wreg_o}, 32'd0);
        chk("undef_aluop", {24'd0, aluop_o}, 32'd0);

        // LUI $4,0xBEEF
        pc_i = 32'h404; inst_i = i_imm(6'b001111, 5'd4, 5'd0, 16'hBEEF);
        step();
        chk("lui_reg1", reg1_o, 32'hBEEF_0000);
        chk("lui_wd", {27'd0, wd_o}, 32'd4);
        chk("lui_inst", {31'd0, instvalid_o}, 32'd1);
        chk("lui_aluop", {24'd0, aluop_o}, 32'h25);

        // Reset during a stall clears output and counter
        pc_i = 32'h408; inst_i = i_imm(6'b001101, 5'd5, 5'd2, 16'h0);
        fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd2}; fwd_pend_i = 2'b01;
        step();
        chk("pre_rst_stall", {16'd0, stall_cnt_o}, 32'd3);
        rst = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
        chk("mid_rst_stall", {16'd0, stall_cnt_o}, 32'd0);
        rst = 1'b0; in_valid = 1'b0; no_fwd();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_fwd_stage.md
# id_fwd_stage

Parametrised, registered instruction-decode stage for the five-stage MIPS pipeline. It sits between IF/ID and EX. It decodes the logic-class subset, resolves operands from the register file or from NUM_FWD forwarding sources in priority order, and detects load-use hazards. It presents one decoded instruction per cycle through a valid/ready handshake, with stall, flush and bubble handling.

## Interface
- DATA_W, 32, datapath and operand width
- REG_AW, 5, register address width
- NUM_FWD, 2, number of forwarding sources; index 0 is the youngest (EX) and has the highest priority
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_valid  in  1  IF/ID holds an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- pc_i  in  32  instruction address
- inst_i  in  32  instruction word
- reg1_addr_o, reg2_addr_o  out  REG_AW  register-file read addresses (combinational)
- reg1_data_i, reg2_data_i  in  DATA_W  register-file read data, same cycle
- fwd_wreg_i  in  NUM_FWD  source k writes a register
- fwd_wd_i  in  NUM_FWD*REG_AW  destination of source k; slice k sits at [k*REG_AW +: REG_AW]
- fwd_wdata_i  in  NUM_FWD*DATA_W  result of source k
- fwd_pend_i  in  NUM_FWD  source k's result is not yet available (load in flight)
- flush_i  in  1  discard the held and incoming instruction
- ex_ready_i  in  1  EX accepts the output
- out_valid_o  out  1  output register holds an instruction
- pc_o  out  32, aluop_o  out  8, alusel_o  out  3, reg1_o, reg2_o  out  DATA_W, wd_o  out  REG_AW, wreg_o  out  1, instvalid_o  out  1  registered decoded fields
- stall_cnt_o  out  16  saturating count of hazard-stall cycles

## Operation
- Decode is combinational from inst_i. The op field is [31:26], rs is [25:21], rt is [20:16], rd is [15:11], funct is [5:0].
  - ORI 001101, ANDI 001100, XORI 001110: rs is read, the immediate is zero-extended [15:0], wd = rt, wreg = 1.
  - LUI 001111: no register is read, imm = {inst[15:0], 16'h0}, wd = rt, wreg = 1, aluop = OR.
  - SPECIAL 000000 with funct AND 100100, OR 100101, XOR 100110, NOR 100111: rs and rt are read, wd = rd, wreg = 1.
  - alusel = LOGIC for all of the above.
  - Any other encoding: instvalid = 0, wreg = 0, aluop = NOP, alusel = NOP. The instruction still flows through the stage.
- Operand select, applied per operand when that operand is read:
  - Address 0 gives 0 and is never forwarded.
  - Otherwise use the lowest index k with fwd_wreg[k] && fwd_wd[k] == addr; the value is fwd_wdata[k].
  - If no source matches, use the register-file data.
  - An operand that is not read takes imm. A second operand that is neither read nor immediate takes 0.
- Hazard: asserted when in_valid is high and the selected (highest-priority) matching source for any read operand has fwd_pend = 1. A lower-priority pending match that is shadowed by a younger non-pending match is not a hazard.
- in_ready = flush_i | (!hazard & (ex_ready_i | !out_valid_o)).
- Output register update, in priority order:
  - rst clears it.
  - Else flush_i clears out_valid; the input is dropped.
  - Else, if ex_ready_i or !out_valid: it loads the decode when in_valid and no hazard; otherwise out_valid becomes 0 (bubble).
  - Else it holds all fields unchanged.
- stall_cnt increments by 1 on each cycle with hazard && !flush_i. It saturates at 16'hFFFF.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N. Full throughput is 1 instruction per cycle.
- Reset values: out_valid 0, aluop 8'h00 (NOP), alusel 3'b000, reg1/reg2 0, wd 0, wreg 0, instvalid 0, pc_o 0, stall_cnt 0.
- Reset or flush mid-stall takes effect on the next edge. The stall counter is not cleared by flush.
- Outputs are stable while out_valid && !ex_ready.
- A hazard produces exactly one bubble per cycle until fwd_pend drops. The instruction is re-decoded with the now-valid forwarded data.
- Simultaneous flush and hazard: flush wins and no stall is counted.

## Structure
- The opcode, funct, aluop and alusel codes, NOPRegAddr and ZeroWord live in the shared defines.v. Add EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP and EXE_ANDI, EXE_XORI, EXE_LUI, EXE_SPECIAL there.
- Sub-module fwd_mux: one per operand, parametrised on NUM_FWD/DATA_W/REG_AW. Outputs are the selected data and a pend flag.

## Test plan
- After reset, ORI $1,$0,0x1234 with ex_ready = 1 → next cycle out_valid = 1, reg1 = 0, reg2 = 0x00001234, wd = 1, wreg = 1.
- OR $3,$1,$2 with fwd0 writing $1 = 0xAAAA0000 and fwd1 writing $1 = 0x5555 → reg1 = 0xAAAA0000 (index 0 wins).
- fwd0 targets $1 with pend = 1 for 2 cycles, then pend = 0 → in_ready low for 2 cycles, 2 bubbles, then the instruction is issued with the forwarded value; stall_cnt = 2.
- ex_ready = 0 for 3 cycles with out_valid = 1 → outputs are frozen and in_ready = 0. No instruction is lost or duplicated.
- flush_i during a stall → out_valid = 0 next cycle, the input is discarded, and stall_cnt is not incremented.
- An undefined opcode 6'b111111 → instvalid = 0, wreg = 0. Separately, LUI $4,0xBEEF → reg1 = 0xBEEF0000 path, wd = 4.
